// File: rtl/fpga_reset_sequencer_if.sv
// Board-reset sequencer signal bundle: PLL lock / ndmreset in, sequenced resets and status out.
// master drives the board-side inputs; slave is the sequencer itself.
interface fpga_reset_sequencer_if;
    logic       pll_locked_i;
    logic       ndmreset_i;
    logic       soc_rst_no;
    logic       core_rst_no;
    logic [1:0] state_o;
    logic [7:0] lock_loss_cnt_o;

    modport master (
        output pll_locked_i,
        output ndmreset_i,
        input  soc_rst_no,
        input  core_rst_no,
        input  state_o,
        input  lock_loss_cnt_o
    );

    modport slave (
        input  pll_locked_i,
        input  ndmreset_i,
        output soc_rst_no,
        output core_rst_no,
        output state_o,
        output lock_loss_cnt_o
    );
endinterface

// File: rtl/fpga_reset_sequencer.sv
// Board-level reset sequencer: qualifies PLL lock, releases fabric then core reset in order,
// and stretches debug ndmreset requests on the core reset.
module fpga_reset_sequencer #(
    parameter int unsigned LockStableCycles  = 1024,
    parameter int unsigned FabricToCoreDelay = 16,
    parameter int unsigned NdmResetMinCycles = 8,
    parameter int unsigned SyncStages        = 2
) (
    input logic                   clk_i,
    input logic                   rst_ni,
    fpga_reset_sequencer_if.slave bus
);

    localparam int unsigned MaxAB  = (LockStableCycles > FabricToCoreDelay) ?
                                     LockStableCycles : FabricToCoreDelay;
    localparam int unsigned MaxAll = (MaxAB > NdmResetMinCycles) ? MaxAB : NdmResetMinCycles;
    localparam int unsigned CntW   = $clog2(MaxAll + 1);

    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t LockLast = cnt_t'(LockStableCycles - 1);
    localparam cnt_t FabLast  = cnt_t'(FabricToCoreDelay - 1);
    localparam cnt_t NdmLast  = cnt_t'(NdmResetMinCycles - 1);

    typedef enum logic [1:0] {
        StWaitLock = 2'd0,
        StFabricUp = 2'd1,
        StRun      = 2'd2,
        StNdmHold  = 2'd3
    } state_e;

    state_e                state_q, state_d;
    cnt_t                  cnt_q, cnt_d;
    logic [7:0]            loss_q, loss_d;
    logic                  soc_q, soc_d;
    logic                  core_q, core_d;
    logic [SyncStages-1:0] sync_q;
    logic                  lock_s;

    assign lock_s = sync_q[SyncStages-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            state_q <= StWaitLock;
            cnt_q   <= '0;
            loss_q  <= '0;
            soc_q   <= 1'b0;
            core_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SyncStages-2:0], bus.pll_locked_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            loss_q  <= loss_d;
            soc_q   <= soc_d;
            core_q  <= core_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        loss_d  = loss_q;
        unique case (state_q)
            StWaitLock: begin
                if (!lock_s) begin
                    cnt_d = '0;
                end else if (cnt_q == LockLast) begin
                    state_d = StFabricUp;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            StFabricUp: begin
                // A pending ndmreset freezes the fabric-to-core countdown.
                if (!bus.ndmreset_i) begin
                    if (cnt_q == FabLast) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + cnt_t'(1);
                    end
                end
            end
            StRun: begin
                if (bus.ndmreset_i) begin
                    state_d = StNdmHold;
                    cnt_d   = '0;
                end
            end
            StNdmHold: begin
                if (cnt_q != NdmLast) begin
                    cnt_d = cnt_q + cnt_t'(1);
                end else if (!bus.ndmreset_i) begin
                    state_d = StFabricUp;
                    cnt_d   = '0;
                end
            end
            default: ;
        endcase

        // Lock loss after first release overrides every other transition.
        if (state_q != StWaitLock && !lock_s) begin
            state_d = StWaitLock;
            cnt_d   = '0;
            if (loss_q != 8'hff) begin
                loss_d = loss_q + 8'd1;
            end
        end

        soc_d  = (state_d != StWaitLock);
        core_d = (state_d == StRun);
    end

    assign bus.soc_rst_no      = soc_q;
    assign bus.core_rst_no     = core_q;
    assign bus.state_o         = state_q;
    assign bus.lock_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_fpga_reset_sequencer.sv
// Self-checking bench for fpga_reset_sequencer: directed scenarios plus randomized lock/ndmreset
// traffic, all compared every cycle against a behavioural model of the release rules.
module tb_fpga_reset_sequencer;

    localparam int LockN = 8;
    localparam int FabN  = 4;
    localparam int NdmN  = 3;
    localparam int SyncN = 2;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    fpga_reset_sequencer_if bus();

    fpga_reset_sequencer #(
        .LockStableCycles (LockN),
        .FabricToCoreDelay(FabN),
        .NdmResetMinCycles(NdmN),
        .SyncStages       (SyncN)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    initial forever #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    // Model: lock history, "fabric released", "core released", "ndm stretch active".
    bit m_hist[SyncN];
    int m_run, m_age, m_loss;
    bit m_soc, m_core, m_hold;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SyncN; i++) m_hist[i] = 1'b0;
        m_run = 0; m_age = 0; m_loss = 0;
        m_soc = 1'b0; m_core = 1'b0; m_hold = 1'b0;
    endtask

    task automatic model_step(input bit lk, input bit nd);
        bit ls;
        ls = m_hist[SyncN-1];
        if (!m_soc) begin
            m_run = ls ? m_run + 1 : 0;
            if (m_run >= LockN) begin
                m_soc = 1'b1; m_age = 0; m_run = 0;
            end
        end else if (!ls) begin
            m_soc = 1'b0; m_core = 1'b0; m_hold = 1'b0; m_age = 0;
            if (m_loss < 255) m_loss++;
        end else if (m_core) begin
            if (nd) begin
                m_core = 1'b0; m_hold = 1'b1; m_age = 0;
            end
        end else if (m_hold) begin
            if (m_age >= NdmN - 1 && !nd) begin
                m_hold = 1'b0; m_age = 0;
            end else begin
                m_age++;
            end
        end else if (!nd) begin
            if (m_age >= FabN - 1) m_core = 1'b1;
            else m_age++;
        end
        for (int i = SyncN - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = lk;
    endtask

    function automatic int exp_state();
        if (!m_soc) return 0;
        if (m_core) return 2;
        if (m_hold) return 3;
        return 1;
    endfunction

    task automatic compare_all();
        check("soc_rst_no", 32'(bus.soc_rst_no), 32'(m_soc));
        check("core_rst_no", 32'(bus.core_rst_no), 32'(m_core));
        check("state_o", 32'(bus.state_o), exp_state());
        check("lock_loss_cnt", 32'(bus.lock_loss_cnt_o), m_loss);
        check("core_implies_soc", 32'(!bus.core_rst_no || bus.soc_rst_no), 1);
    endtask

    task automatic cyc(input bit lk, input bit nd);
        @(negedge clk_i);
        bus.pll_locked_i = lk;
        bus.ndmreset_i   = nd;
        @(posedge clk_i);
        if (rst_ni) model_step(lk, nd);
        #1;
        compare_all();
    endtask

    // Asserts reset away from any clock edge and checks outputs clear immediately.
    task automatic async_reset(input bit lk);
        bus.pll_locked_i = lk;
        rst_ni = 1'b0;
        #1;
        model_reset();
        compare_all();
        cyc(lk, 1'b0);
        cyc(lk, 1'b0);
        rst_ni = 1'b1;
    endtask

    int soc_edge, core_edge, low, edges, nd_left, lk_left;
    bit lk, nd;

    initial begin
        bus.pll_locked_i = 1'b1;
        bus.ndmreset_i   = 1'b0;

        // Power-up with lock held
        async_reset(1'b1);
        soc_edge = 0; core_edge = 0;
        for (int e = 1; e <= 40; e++) begin
            cyc(1'b1, 1'b0);
            if (soc_edge == 0 && bus.soc_rst_no) soc_edge = e;
            if (core_edge == 0 && bus.core_rst_no) core_edge = e;
        end
        check("pwr_soc_edge", soc_edge, SyncN + LockN);
        check("pwr_core_gap", core_edge - soc_edge, FabN);

        // Single-cycle lock glitch while qualifying
        async_reset(1'b1);
        soc_edge = 0;
        for (int e = 1; e <= 40; e++) begin
            cyc(e != 8, 1'b0);
            if (soc_edge == 0 && bus.soc_rst_no) soc_edge = e;
        end
        check("glitch_soc_edge", soc_edge, 18);
        check("glitch_no_loss", 32'(bus.lock_loss_cnt_o), 0);

        // One-cycle ndmreset in RUN
        cyc(1'b1, 1'b1);
        low = bus.core_rst_no ? 0 : 1;
        for (int i = 0; i < 40 && !bus.core_rst_no; i++) begin
            cyc(1'b1, 1'b0);
            if (!bus.core_rst_no) low++;
        end
        check("ndm_pulse_low", low, NdmN + FabN);
        check("ndm_pulse_soc", 32'(bus.soc_rst_no), 1);

        // ndmreset held for 20 cycles
        low = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b1);
            if (!bus.core_rst_no) low++;
        end
        check("ndm_long_held", 32'(bus.core_rst_no), 0);
        for (int i = 0; i < 40 && !bus.core_rst_no; i++) begin
            cyc(1'b1, 1'b0);
            if (!bus.core_rst_no) low++;
        end
        check("ndm_long_low", low, 20 + FabN);

        // Lock loss in RUN
        edges = 0;
        for (int i = 0; i < 10 && (bus.soc_rst_no || bus.core_rst_no); i++) begin
            cyc(1'b0, 1'b0);
            edges++;
        end
        check("loss_edges", edges, SyncN + 1);
        check("loss_cnt_one", 32'(bus.lock_loss_cnt_o), 1);
        for (int i = 0; i < 40 && !bus.core_rst_no; i++) cyc(1'b1, 1'b0);
        check("relock_run", 32'(bus.state_o), 2);

        // Loss counter saturation
        for (int n = 0; n < 300; n++) begin
            for (int i = 0; i < 11; i++) cyc(1'b1, 1'b0);
            for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0);
        end
        check("loss_cnt_sat", 32'(bus.lock_loss_cnt_o), 255);

        // Async reset in NDM_HOLD, then in FABRIC_UP
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0);
        cyc(1'b1, 1'b1);
        cyc(1'b1, 1'b0);
        check("pre_rst_ndm_hold", 32'(bus.state_o), 3);
        async_reset(1'b1);
        check("rst_ndm_loss_zero", 32'(bus.lock_loss_cnt_o), 0);
        for (int i = 0; i < 11; i++) cyc(1'b1, 1'b0);
        check("pre_rst_fabric_up", 32'(bus.state_o), 1);
        async_reset(1'b1);

        // Randomized lock drops and ndmreset bursts
        nd_left = 0; lk_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (lk_left > 0) begin
                lk_left--;
                lk = 1'b0;
            end else begin
                lk = 1'b1;
                if ($urandom_range(0, 59) == 0) lk_left = $urandom_range(0, 4);
            end
            if (nd_left > 0) begin
                nd_left--;
                nd = 1'b1;
            end else begin
                nd = 1'b0;
                if ($urandom_range(0, 11) == 0) nd_left = $urandom_range(1, 25);
            end
            cyc(lk, nd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
